// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack-machine controller: opcodes, ALU codes,
// FSM state encoding and datapath mux-select values.
package stack_ctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;
  localparam logic SRC_MEM = 1'b0;
  localparam logic SRC_ALU = 1'b1;
  localparam logic AIN_PC  = 1'b0;
  localparam logic AIN_A   = 1'b1;
  localparam logic BIN_ONE = 1'b0;
  localparam logic BIN_B   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_POP_A    = 4'd3,
    S_POP_B    = 4'd4,
    S_EXEC     = 4'd5,
    S_PUSH_RES = 4'd6,
    S_MEM_RD   = 4'd7,
    S_PUSH_MEM = 4'd8,
    S_POP_ST   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_JMP      = 4'd11,
    S_JZ_TOS   = 4'd12,
    S_JZ_BR    = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  // States that wait on memory and are therefore watched by the timeout timer.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags expiry on the
// TIMEOUT-th waiting cycle. TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + TW'(1);
    end
  end

  // cnt holds the number of earlier waiting cycles, so LAST marks the final allowed one.
  assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle sequencer for the stack-machine datapath: fetch, decode,
// stack pop/push, ALU execute, memory load/store and jumps.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | post-reset, no strobes
// FETCH    | read instruction at PC, PC <- PC+1 when memory ready
// DECODE   | dispatch on opcode
// POP_A    | pop top of stack into regA
// POP_B    | pop next entry into regB (binary ops only)
// EXEC     | ALU operates on regA/regB
// PUSH_RES | push ALU result, retire
// MEM_RD   | read memory at IR[4:0]
// PUSH_MEM | push read data, retire
// POP_ST   | pop store data into regA
// MEM_WR   | write regA to IR[4:0], retire on ready
// JMP      | PC <- IR[4:0], retire
// JZ_TOS   | peek top of stack into regA (no pop)
// JZ_BR    | conditional jump, retire
// FAULT    | stack guard or memory timeout tripped; held until rst
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  input  logic             stack_empty,
  input  logic             stack_full,
  output logic             LorD,
  output logic             read,
  output logic             write,
  output logic             StackSrc,
  output logic             tos,
  output logic             push,
  output logic             pop,
  output logic             RegDst,
  output logic             LA,
  output logic             LB,
  output logic             Ain,
  output logic             Bin,
  output logic [1:0]       ALUop,
  output logic             next,
  output logic             jump,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             fault
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_lo;
  logic       retire;
  logic       tmr_expired;
  logic       tmr_enable;
  logic       tmr_clear;

  assign tmr_enable = is_wait_state(state_q) && !mem_ready;
  assign tmr_clear  = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_lo       <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      // Only the ALU-select bits are needed after decode.
      if (state_q == S_DECODE) begin
        op_lo <= opcode[1:0];
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Stack guards divert to FAULT on the edge that would enter the strobing state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_NOT:
                   state_d = stack_empty ? S_FAULT : S_POP_A;
          OP_PUSH: state_d = S_MEM_RD;
          OP_POP:  state_d = stack_empty ? S_FAULT : S_POP_ST;
          OP_JMP:  state_d = S_JMP;
          OP_JZ:   state_d = stack_empty ? S_FAULT : S_JZ_TOS;
          default: state_d = S_FAULT;
        endcase
      end
      S_POP_A: begin
        if (op_lo == ALU_NOT) state_d = S_EXEC;
        else                  state_d = stack_empty ? S_FAULT : S_POP_B;
      end
      S_POP_B:    state_d = S_EXEC;
      S_EXEC:     state_d = stack_full ? S_FAULT : S_PUSH_RES;
      S_PUSH_RES: state_d = S_FETCH;
      S_MEM_RD: begin
        if (mem_ready)        state_d = stack_full ? S_FAULT : S_PUSH_MEM;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_PUSH_MEM: state_d = S_FETCH;
      S_POP_ST:   state_d = S_MEM_WR;
      S_MEM_WR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_JMP:      state_d = S_FETCH;
      S_JZ_TOS:   state_d = S_JZ_BR;
      S_JZ_BR:    state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_PUSH_RES, S_PUSH_MEM, S_JMP, S_JZ_BR: retire = 1'b1;
      S_MEM_WR:                               retire = mem_ready;
      default:                                retire = 1'b0;
    endcase
  end

  always_comb begin
    LorD       = ADDR_PC;
    read       = 1'b0;
    write      = 1'b0;
    StackSrc   = SRC_MEM;
    tos        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    RegDst     = 1'b0;
    LA         = 1'b0;
    LB         = 1'b0;
    Ain        = AIN_PC;
    Bin        = BIN_ONE;
    ALUop      = ALU_ADD;
    next       = 1'b0;
    jump       = 1'b0;
    instr_done = retire;
    fault      = (state_q == S_FAULT);
    case (state_q)
      S_FETCH: begin
        read  = 1'b1;
        LorD  = ADDR_PC;
        Ain   = AIN_PC;
        Bin   = BIN_ONE;
        ALUop = ALU_ADD;
        next  = mem_ready;
      end
      S_POP_A, S_POP_ST: begin
        tos    = 1'b1;
        pop    = 1'b1;
        RegDst = 1'b1;
        LA     = 1'b1;
      end
      S_POP_B: begin
        tos    = 1'b1;
        pop    = 1'b1;
        RegDst = 1'b0;
        LB     = 1'b1;
      end
      S_EXEC: begin
        Ain   = AIN_A;
        Bin   = BIN_B;
        ALUop = op_lo;
      end
      S_PUSH_RES: begin
        StackSrc = SRC_ALU;
        push     = 1'b1;
      end
      S_MEM_RD: begin
        read = 1'b1;
        LorD = ADDR_IR;
      end
      S_PUSH_MEM: begin
        read     = 1'b1;
        LorD     = ADDR_IR;
        StackSrc = SRC_MEM;
        push     = 1'b1;
      end
      S_MEM_WR: begin
        write = 1'b1;
        LorD  = ADDR_IR;
      end
      S_JMP, S_JZ_BR: jump = 1'b1;
      S_JZ_TOS: begin
        tos    = 1'b1;
        RegDst = 1'b1;
        LA     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: per-cycle expected control words are
// queued as stimulus is driven and checked at the following falling edge.
module tb_stack_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    opcode;
  logic          mem_ready;
  logic          stack_empty;
  logic          stack_full;
  logic          LorD, read, write, StackSrc, tos, push, pop, RegDst;
  logic          LA, LB, Ain, Bin, next, jump, instr_done, fault;
  logic [1:0]    ALUop;
  logic [CW-1:0] instr_count;
  logic [17:0]   ctl;

  stack_controller #(
    .CNT_W   (CW),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .LorD        (LorD),
    .read        (read),
    .write       (write),
    .StackSrc    (StackSrc),
    .tos         (tos),
    .push        (push),
    .pop         (pop),
    .RegDst      (RegDst),
    .LA          (LA),
    .LB          (LB),
    .Ain         (Ain),
    .Bin         (Bin),
    .ALUop       (ALUop),
    .next        (next),
    .jump        (jump),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  assign ctl = {LorD, read, write, StackSrc, tos, push, pop, RegDst,
                LA, LB, Ain, Bin, ALUop, next, jump, instr_done, fault};

  // Bit order: LorD read write StackSrc tos push pop RegDst LA LB Ain Bin ALUop[1:0] next jump done fault
  localparam logic [17:0] C_IDLE      = 18'h00000;
  localparam logic [17:0] C_FETCH_RDY = 18'h10008;
  localparam logic [17:0] C_FETCH_WT  = 18'h10000;
  localparam logic [17:0] C_DECODE    = 18'h00000;
  localparam logic [17:0] C_POP_A     = 18'h02E00;
  localparam logic [17:0] C_POP_B     = 18'h02900;
  localparam logic [17:0] C_EXEC_ADD  = 18'h000C0;
  localparam logic [17:0] C_EXEC_SUB  = 18'h000D0;
  localparam logic [17:0] C_EXEC_NOT  = 18'h000F0;
  localparam logic [17:0] C_PUSH_RES  = 18'h05002;
  localparam logic [17:0] C_MEM_RD    = 18'h30000;
  localparam logic [17:0] C_PUSH_MEM  = 18'h31002;
  localparam logic [17:0] C_MEM_WR    = 18'h28000;
  localparam logic [17:0] C_MEM_WR_OK = 18'h28002;
  localparam logic [17:0] C_JUMP      = 18'h00006;
  localparam logic [17:0] C_JZ_TOS    = 18'h02600;
  localparam logic [17:0] C_FAULT     = 18'h00001;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [17:0] exp_q[$];
  string       tag_q[$];

  task automatic cyc(input logic rdy, input logic [17:0] exp, input string tag);
    logic [17:0] e;
    string       t;
    mem_ready = rdy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (ctl === e) else begin
      miscompares++;
      $error("FAIL %s observed ctl=%h expected ctl=%h", t, ctl, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [CW-1:0] exp, input string tag);
    vectors++;
    assert (instr_count === exp) else begin
      miscompares++;
      $error("FAIL %s observed count=%0d expected count=%0d", tag, instr_count, exp);
    end
  endtask

  task automatic do_jmp();
    opcode = 3'b110;
    cyc(1'b1, C_FETCH_RDY, "jmp_fetch");
    cyc(1'b1, C_DECODE, "jmp_decode");
    cyc(1'b1, C_JUMP, "jmp_jump");
  endtask

  task automatic reset_from_fault(input string tag);
    rst = 1'b1;
    cyc(1'b0, C_FAULT, tag);
    rst = 1'b0;
    cyc(1'b0, C_IDLE, "idle_after_rst");
  endtask

  initial begin
    rst         = 1'b1;
    opcode      = 3'b000;
    mem_ready   = 1'b0;
    stack_empty = 1'b0;
    stack_full  = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, C_IDLE, "reset_outputs");
    chk_cnt(0, "reset_count");
    rst = 1'b0;
    cyc(1'b0, C_IDLE, "idle");

    opcode = 3'b000;
    cyc(1'b1, C_FETCH_RDY, "add_fetch");
    cyc(1'b1, C_DECODE, "add_decode");
    cyc(1'b1, C_POP_A, "add_pop_a");
    cyc(1'b1, C_POP_B, "add_pop_b");
    cyc(1'b1, C_EXEC_ADD, "add_exec");
    cyc(1'b1, C_PUSH_RES, "add_push_res");
    chk_cnt(1, "add_count");

    opcode = 3'b001;
    cyc(1'b1, C_FETCH_RDY, "sub_fetch");
    cyc(1'b1, C_DECODE, "sub_decode");
    cyc(1'b1, C_POP_A, "sub_pop_a");
    cyc(1'b1, C_POP_B, "sub_pop_b");
    cyc(1'b1, C_EXEC_SUB, "sub_exec");
    cyc(1'b1, C_PUSH_RES, "sub_push_res");

    opcode = 3'b011;
    cyc(1'b1, C_FETCH_RDY, "not_fetch");
    cyc(1'b1, C_DECODE, "not_decode");
    cyc(1'b1, C_POP_A, "not_pop_a");
    cyc(1'b1, C_EXEC_NOT, "not_exec");
    cyc(1'b1, C_PUSH_RES, "not_push_res");
    chk_cnt(3, "not_count");

    opcode = 3'b100;
    cyc(1'b1, C_FETCH_RDY, "push_fetch");
    cyc(1'b1, C_DECODE, "push_decode");
    for (int i = 0; i < 3; i++) cyc(1'b0, C_MEM_RD, "push_mem_rd_wait");
    cyc(1'b1, C_MEM_RD, "push_mem_rd_ready");
    cyc(1'b1, C_PUSH_MEM, "push_push_mem");
    chk_cnt(4, "push_count");

    opcode = 3'b111;
    cyc(1'b1, C_FETCH_RDY, "jz_fetch");
    cyc(1'b1, C_DECODE, "jz_decode");
    cyc(1'b1, C_JZ_TOS, "jz_tos");
    cyc(1'b1, C_JUMP, "jz_br");

    opcode = 3'b101;
    cyc(1'b1, C_FETCH_RDY, "pop_fetch");
    cyc(1'b1, C_DECODE, "pop_decode");
    cyc(1'b1, C_POP_A, "pop_pop_st");
    cyc(1'b0, C_MEM_WR, "pop_mem_wr_wait");
    cyc(1'b1, C_MEM_WR_OK, "pop_mem_wr_done");
    chk_cnt(6, "pop_count");

    opcode = 3'b110;
    for (int i = 0; i < 14; i++) cyc(1'b0, C_FETCH_WT, "fetch_wait_14");
    cyc(1'b1, C_FETCH_RDY, "fetch_ready_cycle15");
    cyc(1'b1, C_DECODE, "fetch15_decode");
    cyc(1'b1, C_JUMP, "fetch15_jmp");
    chk_cnt(7, "fetch15_count");

    for (int i = 0; i < 8; i++) do_jmp();
    chk_cnt(15, "count_max");
    do_jmp();
    chk_cnt(0, "count_wrap");
    do_jmp();
    chk_cnt(1, "count_after_wrap");

    opcode = 3'b101;
    cyc(1'b1, C_FETCH_RDY, "rstwr_fetch");
    cyc(1'b1, C_DECODE, "rstwr_decode");
    cyc(1'b1, C_POP_A, "rstwr_pop_st");
    rst = 1'b1;
    cyc(1'b0, C_MEM_WR, "rstwr_mem_wr");
    rst = 1'b0;
    cyc(1'b0, C_IDLE, "rst_in_mem_wr");
    chk_cnt(0, "rst_in_mem_wr_count");

    opcode = 3'b101;
    cyc(1'b1, C_FETCH_RDY, "pop_empty_fetch");
    stack_empty = 1'b1;
    cyc(1'b1, C_DECODE, "pop_empty_decode");
    for (int i = 0; i < 4; i++) cyc(i[0], C_FAULT, "pop_empty_fault");
    stack_empty = 1'b0;
    cyc(1'b1, C_FAULT, "fault_sticky");
    reset_from_fault("pop_empty_rst");

    opcode = 3'b110;
    for (int i = 0; i < 15; i++) cyc(1'b0, C_FETCH_WT, "timeout_wait");
    cyc(1'b0, C_FAULT, "fetch_timeout");
    cyc(1'b1, C_FAULT, "timeout_sticky");
    reset_from_fault("timeout_rst");

    opcode = 3'b010;
    cyc(1'b1, C_FETCH_RDY, "and_fetch");
    cyc(1'b1, C_DECODE, "and_decode");
    stack_empty = 1'b1;
    cyc(1'b1, C_POP_A, "and_pop_a_last");
    cyc(1'b1, C_FAULT, "and_pop_b_empty");
    stack_empty = 1'b0;
    reset_from_fault("and_rst");

    opcode = 3'b000;
    cyc(1'b1, C_FETCH_RDY, "full_fetch");
    cyc(1'b1, C_DECODE, "full_decode");
    cyc(1'b1, C_POP_A, "full_pop_a");
    cyc(1'b1, C_POP_B, "full_pop_b");
    stack_full = 1'b1;
    cyc(1'b1, C_EXEC_ADD, "full_exec");
    cyc(1'b1, C_FAULT, "push_res_full");
    chk_cnt(0, "full_count");
    stack_full = 1'b0;
    reset_from_fault("full_rst");

    opcode = 3'b100;
    cyc(1'b1, C_FETCH_RDY, "pmfull_fetch");
    cyc(1'b1, C_DECODE, "pmfull_decode");
    stack_full = 1'b1;
    cyc(1'b1, C_MEM_RD, "pmfull_mem_rd");
    cyc(1'b1, C_FAULT, "push_mem_full");
    stack_full = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
